// File: rtl/pattern_101_gen_if.sv
// Request/stream bundle for the "101" pattern transmitter.
// The master side issues parallel pattern requests. The slave side returns the serial
// stream together with its status strobes.
interface pattern_101_gen_if #(
    parameter int PAT_W = 8,
    parameter int REP_W = 4
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic [PAT_W-1:0] pat_i;
    logic [LEN_W-1:0] len_i;
    logic [REP_W-1:0] rep_i;
    logic             valid_i;
    logic             ready_o;
    logic             val_o;
    logic             bit_vld_o;
    logic             exp_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output pat_i, len_i, rep_i, valid_i,
        input  ready_o, val_o, bit_vld_o, exp_o, busy_o, done_o
    );

    modport slave (
        input  pat_i, len_i, rep_i, valid_i,
        output ready_o, val_o, bit_vld_o, exp_o, busy_o, done_o
    );
endinterface

// File: rtl/pattern_101_gen.sv
// Serial "101" pattern transmitter.
// A parallel word is shifted out MSB-first, rep_i+1 times, with GAP_CYC idle cycles after
// every pass. A golden strobe marks each completed 1,0,1 in the stream. Every output is
// registered: the comb block computes the next-cycle image of each output from the next state.
module pattern_101_gen #(
    parameter int PAT_W   = 8,
    parameter int REP_W   = 4,
    parameter int GAP_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    pattern_101_gen_if.slave    bus
);
    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] last_q, last_d;   // index of the first bit of a pass (len-1)
    logic [IDX_W-1:0] idx_q, idx_d;     // index of the bit on val_o this cycle
    logic [REP_W-1:0] pass_q, pass_d;   // passes still to go after the current one
    logic [GAP_W-1:0] gap_q, gap_d;     // gap cycles still to go after the current one
    logic [1:0]       hist_q, hist_d;   // two most recent stream bits; the third is the new bit
    logic             ready_q, ready_d;
    logic             val_q, val_d;
    logic             vld_q, vld_d;
    logic             exp_q, exp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] eff_len;

    // Next-state logic plus the registered image of every output for the next cycle
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        last_d  = last_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        eff_len = (bus.len_i == '0 || bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;

        case (state_q)
            IDLE: begin
                if (bus.valid_i && ready_q) begin
                    pat_d   = bus.pat_i;
                    last_d  = IDX_W'(eff_len - LEN_W'(1));
                    idx_d   = IDX_W'(eff_len - LEN_W'(1));
                    pass_d  = bus.rep_i;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end else if (GAP_CYC > 0) begin
                    gap_d   = GAP_LAST;
                    state_d = GAP;
                end else if (pass_q != '0) begin
                    pass_d = pass_q - REP_W'(1);
                    idx_d  = last_q;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (pass_q != '0) begin
                    pass_d  = pass_q - REP_W'(1);
                    idx_d   = last_q;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        vld_d   = (state_d == SHIFT);
        val_d   = vld_d ? pat_d[idx_d] : 1'b0;
        exp_d   = vld_d && ({hist_q, val_d} == 3'b101);
        hist_d  = vld_d ? {hist_q[0], val_d} : hist_q;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // Control state and registered outputs; reset drops any job in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            gap_q   <= '0;
            hist_q  <= '0;
            ready_q <= 1'b1;
            val_q   <= 1'b0;
            vld_q   <= 1'b0;
            exp_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            gap_q   <= gap_d;
            hist_q  <= hist_d;
            ready_q <= ready_d;
            val_q   <= val_d;
            vld_q   <= vld_d;
            exp_q   <= exp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Latched request data; only meaningful while a job is active
    always_ff @(posedge clk) begin
        pat_q  <= pat_d;
        last_q <= last_d;
    end

    assign bus.ready_o   = ready_q;
    assign bus.val_o     = val_q;
    assign bus.bit_vld_o = vld_q;
    assign bus.exp_o     = exp_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
endmodule
